// File: rtl/seg_scan_sched_pkg.sv
// Shared constants, state encoding and small helpers for the 7-segment scan scheduler.
package seg_scan_sched_pkg;

    localparam int FRAME_W          = 16;
    localparam int DEF_DIGITS       = 6;
    localparam int DEF_SCAN_DIV     = 50_000;
    localparam int DEF_BLINK_FRAMES = 250;

    localparam logic [7:0]         SEG_BLANK   = 8'hFF;
    localparam logic [FRAME_W-1:0] FRAME_BLANK = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_REQ  = 2'd2,
        ST_ADV  = 2'd3
    } state_e;

    // Active-low one-hot digit select for the given scan index.
    function automatic logic [7:0] sel_onehot_n(input logic [2:0] idx);
        return ~(8'b0000_0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_sched_if.sv
// Frame handshake between the scan scheduler and the 74HC595 serializer.
interface seg_scan_sched_if;

    logic [seg_scan_sched_pkg::FRAME_W-1:0] frame_data;
    logic                                   frame_req;
    logic                                   frame_ack;

    modport master (output frame_data, output frame_req, input frame_ack);
    modport slave  (input frame_data, input frame_req, output frame_ack);

endinterface

// File: rtl/seg_scan_sched_decode.sv
// BCD to active-low gfedcba segment pattern; codes 10..15 render blank.
module seg_scan_sched_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Segment lookup table.
    always_comb begin
        seg_n = 7'h7F;
        case (bcd)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_sched.sv
// Scan scheduler: one digit frame per scan tick, handed to the serializer over req/ack.
module seg_scan_sched
    import seg_scan_sched_pkg::*;
#(
    parameter int DIGITS       = DEF_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_bcd,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  disp_en,
    seg_scan_sched_if.master      fbus,
    output logic [2:0]            scan_idx,
    output logic                  blink_phase,
    output logic                  overrun
);

    localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int             BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [DIV_W-1:0]     div_cnt_r;
    logic                 tick_s;
    logic [BLK_W-1:0]     blink_cnt_r;
    logic                 blink_phase_r;
    logic [2:0]           scan_idx_r;
    logic                 overrun_r;
    logic [FRAME_W-1:0]   frame_data_r;
    logic                 frame_req_r;
    logic [FRAME_W-1:0]   frame_s;
    logic                 sweep_end_s;

    // Inputs padded to the 8-digit maximum so the index select is always in range.
    logic [31:0]          bcd_pad_s;
    logic [7:0]           dp_pad_s;
    logic [7:0]           blink_pad_s;
    logic [3:0]           cur_bcd_s;
    logic [6:0]           dec_seg_s;

    assign bcd_pad_s   = 32'(digit_bcd);
    assign dp_pad_s    = 8'(dp_mask);
    assign blink_pad_s = 8'(blink_mask);
    assign cur_bcd_s   = bcd_pad_s[{scan_idx_r, 2'b00} +: 4];
    assign tick_s      = (div_cnt_r == DIV_LAST);
    assign sweep_end_s = (scan_idx_r == IDX_LAST);

    seg_scan_sched_decode u_decode (
        .bcd   (cur_bcd_s),
        .seg_n (dec_seg_s)
    );

    // Free-running scan divider producing a one-cycle tick.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

    // Scheduler state register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; ack only matters while a frame is being offered.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) state_nxt_s = ST_LOAD;
                else        state_nxt_s = ST_IDLE;
            end
            ST_LOAD: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (fbus.frame_ack) state_nxt_s = ST_ADV;
                else                state_nxt_s = ST_REQ;
            end
            ST_ADV:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame composition for the current digit; blanking keeps the digit select.
    always_comb begin
        frame_s = FRAME_BLANK;
        if (!disp_en) begin
            frame_s = FRAME_BLANK;
        end else if (blink_phase_r && blink_pad_s[scan_idx_r]) begin
            frame_s = {SEG_BLANK, sel_onehot_n(scan_idx_r)};
        end else begin
            frame_s = {~dp_pad_s[scan_idx_r], dec_seg_s, sel_onehot_n(scan_idx_r)};
        end
    end

    // Frame register captures inputs only in LOAD and holds through REQ.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            frame_data_r <= FRAME_BLANK;
        end else if (state_r == ST_LOAD) begin
            frame_data_r <= frame_s;
        end else begin
            frame_data_r <= frame_data_r;
        end
    end

    // Request is high exactly while the FSM sits in REQ.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            frame_req_r <= 1'b0;
        end else begin
            frame_req_r <= (state_nxt_s == ST_REQ);
        end
    end

    // Digit index advances once per accepted frame, wrapping after the last digit.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            scan_idx_r <= 3'd0;
        end else if (state_r == ST_ADV) begin
            scan_idx_r <= sweep_end_s ? 3'd0 : scan_idx_r + 3'd1;
        end else begin
            scan_idx_r <= scan_idx_r;
        end
    end

    // Blink counter counts full sweeps and toggles the phase at the terminal count.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if ((state_r == ST_ADV) && sweep_end_s) begin
            if (blink_cnt_r == BLK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + 1'b1;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Sticky flag: a tick outside IDLE is dropped and remembered.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (tick_s && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign fbus.frame_data = frame_data_r;
    assign fbus.frame_req  = frame_req_r;
    assign scan_idx        = scan_idx_r;
    assign blink_phase     = blink_phase_r;
    assign overrun         = overrun_r;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with DIGITS=6, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_sched;
    import seg_scan_sched_pkg::*;

    localparam int DIGITS       = 6;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int NVEC         = 30;

    logic        sysclk = 1'b0;
    logic        rst    = 1'b1;
    logic [23:0] digit_bcd;
    logic [5:0]  dp_mask;
    logic [5:0]  blink_mask;
    logic        disp_en;
    logic [2:0]  scan_idx;
    logic        blink_phase;
    logic        overrun;

    seg_scan_sched_if fbus ();

    seg_scan_sched #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .digit_bcd   (digit_bcd),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .disp_en     (disp_en),
        .fbus        (fbus),
        .scan_idx    (scan_idx),
        .blink_phase (blink_phase),
        .overrun     (overrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  dp;
        logic [5:0]  blink;
        logic        en;
        logic [15:0] exp_frame;
        logic [2:0]  exp_idx;
        logic        exp_phase;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Bounded wait for frame_req; returns number of edges waited.
    task automatic wait_req(output int cyc);
        cyc = 0;
        while ((fbus.frame_req !== 1'b1) && (cyc < 40)) begin
            step();
            cyc++;
        end
        if (fbus.frame_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_req: frame_req actual 0 required 1 within 40 cycles");
        end
    endtask

    task automatic ack_now();
        fbus.frame_ack = 1'b1;
        step();
        fbus.frame_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        digit_bcd  = v.bcd;
        dp_mask    = v.dp;
        blink_mask = v.blink;
        disp_en    = v.en;
    endtask

    initial begin
        logic [15:0] e1 [6];
        logic [15:0] e2 [6];
        logic [15:0] held;
        int          cyc;
        int          bad_req;
        int          bad_data;

        e1 = '{16'h82FE, 16'h92FD, 16'h19FB, 16'hB0F7, 16'hA4EF, 16'hF9DF};
        e2 = '{16'hC0FE, 16'hF8FD, 16'h00FB, 16'h90F7, 16'h7FEF, 16'hFFDF};

        for (int s = 0; s < 5; s++) begin
            for (int d = 0; d < 6; d++) begin
                vec_t v;
                v.bcd       = 24'h123456;
                v.dp        = 6'b000100;
                v.blink     = 6'b100001;
                v.en        = 1'b1;
                v.exp_idx   = 3'(d);
                v.exp_frame = e1[d];
                v.exp_phase = 1'b0;
                case (s)
                    0: v.blink = 6'b000000;
                    1: v.exp_phase = 1'b0;
                    2: begin
                        v.exp_phase = 1'b1;
                        if (d == 0) v.exp_frame = 16'hFFFE;
                        if (d == 5) v.exp_frame = 16'hFFDF;
                    end
                    3: begin
                        v.exp_phase = 1'b1;
                        v.en        = 1'b0;
                        v.exp_frame = 16'hFFFF;
                    end
                    default: begin
                        v.bcd       = 24'hFA9870;
                        v.dp        = 6'b010100;
                        v.blink     = 6'b000001;
                        v.exp_frame = e2[d];
                    end
                endcase
                vecs[s*6+d] = v;
            end
        end

        fbus.frame_ack = 1'b0;
        apply(vecs[0]);

        // Reset held 3 cycles.
        rst = 1'b1;
        repeat (3) step();
        chk("rst_frame_data", fbus.frame_data, 16'hFFFF);
        chk("rst_frame_req", 16'(fbus.frame_req), 16'h0);
        chk("rst_scan_idx", 16'(scan_idx), 16'h0);
        chk("rst_blink_phase", 16'(blink_phase), 16'h0);
        chk("rst_overrun", 16'(overrun), 16'h0);

        // Tick in the 3rd cycle after release, frame_req on the 5th edge.
        rst = 1'b0;
        wait_req(cyc);
        chk("first_req_latency", 16'(cyc), 16'd5);

        // Table: 5 full sweeps covering encode, blink phases, disp_en=0 and blank codes.
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            wait_req(cyc);
            if (i > 0) chk($sformatf("tick_spacing[%0d]", i), 16'(cyc), 16'd3);
            chk($sformatf("frame[%0d]", i), fbus.frame_data, vecs[i].exp_frame);
            chk($sformatf("idx[%0d]", i), 16'(scan_idx), 16'(vecs[i].exp_idx));
            chk($sformatf("phase[%0d]", i), 16'(blink_phase), 16'(vecs[i].exp_phase));
            ack_now();
            chk($sformatf("req_drop[%0d]", i), 16'(fbus.frame_req), 16'h0);
        end
        chk("overrun_clean", 16'(overrun), 16'h0);

        // Backpressure: ack delayed 10 cycles.
        apply(vecs[0]);
        wait_req(cyc);
        held = fbus.frame_data;
        chk("bp_frame", held, 16'h82FE);
        chk("bp_idx", 16'(scan_idx), 16'd0);
        bad_req  = 0;
        bad_data = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (fbus.frame_req !== 1'b1) bad_req++;
            if (fbus.frame_data !== held) bad_data++;
        end
        chk("bp_req_held_bad_cycles", 16'(bad_req), 16'd0);
        chk("bp_data_held_bad_cycles", 16'(bad_data), 16'd0);
        ack_now();
        chk("bp_overrun", 16'(overrun), 16'h1);
        wait_req(cyc);
        chk("bp_next_frame", fbus.frame_data, 16'h92FD);
        chk("bp_next_idx", 16'(scan_idx), 16'd1);
        ack_now();

        // Stray ack while IDLE is ignored.
        step();
        fbus.frame_ack = 1'b1;
        step();
        fbus.frame_ack = 1'b0;
        chk("stray_req", 16'(fbus.frame_req), 16'h0);
        chk("stray_idx", 16'(scan_idx), 16'd2);
        wait_req(cyc);
        chk("stray_next_frame", fbus.frame_data, 16'h19FB);
        chk("stray_next_idx", 16'(scan_idx), 16'd2);
        step();
        chk("stray_req_still_high", 16'(fbus.frame_req), 16'h1);
        ack_now();

        // Reset during REQ, then a late ack.
        wait_req(cyc);
        chk("mid_frame", fbus.frame_data, 16'hB0F7);
        rst = 1'b1;
        step();
        chk("mid_rst_req", 16'(fbus.frame_req), 16'h0);
        chk("mid_rst_idx", 16'(scan_idx), 16'd0);
        chk("mid_rst_frame", fbus.frame_data, 16'hFFFF);
        chk("mid_rst_overrun", 16'(overrun), 16'h0);
        rst = 1'b0;
        step();
        step();
        fbus.frame_ack = 1'b1;
        step();
        fbus.frame_ack = 1'b0;
        chk("late_ack_req", 16'(fbus.frame_req), 16'h0);
        chk("late_ack_idx", 16'(scan_idx), 16'd0);
        wait_req(cyc);
        chk("post_rst_latency", 16'(cyc), 16'd2);
        chk("post_rst_frame", fbus.frame_data, 16'h82FE);
        chk("post_rst_idx", 16'(scan_idx), 16'd0);
        ack_now();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
